seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 139 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Word-serial "1011" detector: accepts an 8-bit word, scans it MSB first and reports hit count/map.
// Optional SEQ_DETECT_CTRL_HIT_TOTAL_EN adds a saturating running total of hits (hit_total).
module seq_detect_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_chain,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_hits,
    output logic [7:0] out_map,
    input  logic       out_ready,
    output logic       busy
`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
    ,
    output logic [15:0] hit_total
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    state_t     state, state_n;
    det_t       det, det_n;
    logic [7:0] data_q, data_n;
    logic [2:0] idx, idx_n;
    logic [3:0] hits, hits_n;
    logic [7:0] map, map_n;
    logic       valid, valid_n;
    logic       bit_in;
    logic       match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            det    <= S0;
            data_q <= '0;
            idx    <= '0;
            hits   <= '0;
            map    <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_n;
            det    <= det_n;
            data_q <= data_n;
            idx    <= idx_n;
            hits   <= hits_n;
            map    <= map_n;
            valid  <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        det_n   = det;
        data_n  = data_q;
        idx_n   = idx;
        hits_n  = hits;
        map_n   = map;
        valid_n = valid;
        match   = 1'b0;
        bit_in  = data_q[idx];

        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_n  = in_data;
                    idx_n   = 3'd7;
                    hits_n  = '0;
                    map_n   = '0;
                    det_n   = in_chain ? det : S0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                case (det)
                    S0: det_n = bit_in ? S1 : S0;
                    S1: det_n = bit_in ? S1 : S2;
                    S2: det_n = bit_in ? S3 : S0;
                    S3: begin
                        det_n = bit_in ? S1 : S2;
                        match = bit_in;
                    end
                    default: det_n = S0;
                endcase
                if (match) begin
                    hits_n     = hits + 4'd1;
                    map_n[idx] = 1'b1;
                end
                idx_n = idx - 3'd1;
                if (idx == 3'd0)
                    state_n = DONE;
            end
            DONE: begin
                // out_valid is registered: it rises one edge after DONE is entered,
                // giving the accept-to-valid distance of nine edges.
                if (!valid)
                    valid_n = 1'b1;
                else if (out_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (clear) begin
            state_n = IDLE;
            det_n   = S0;
            hits_n  = '0;
            map_n   = '0;
            valid_n = 1'b0;
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = valid;
    assign out_hits  = hits;
    assign out_map   = map;

`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, hit_total} + {13'd0, hits};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hit_total <= '0;
        else if (clear)
            hit_total <= '0;
        else if (valid && out_ready)
            hit_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: vector table of words plus hand-written backpressure,
// reset, clear and (with SEQ_DETECT_CTRL_HIT_TOTAL_EN) saturation sequences.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid, in_chain, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, busy;
    logic [3:0] out_hits;
    logic [7:0] out_map;
`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
    logic [15:0] hit_total;
    logic [15:0] exp_total = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    seq_detect_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_chain  (in_chain),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_hits  (out_hits),
        .out_map   (out_map),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
        ,
        .hit_total (hit_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       chain;
        logic [3:0] hits;
        logic [7:0] map;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one word, time its result, optionally back-pressure, then consume it.
    task automatic run_word(input logic [7:0] d, input logic c, input logic [3:0] eh,
                            input logic [7:0] em, input logic early, input int hold);
        int n;
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_chain  = c;
        out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'({in_ready, busy}), 32'b01);
        for (n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        check("latency", 32'(n), 32'd9);
        check("hits", 32'(out_hits), 32'(eh));
        check("map", 32'(out_map), 32'(em));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_stable", 32'({out_valid, in_ready, out_hits, out_map}),
                  32'({1'b1, 1'b0, eh, em}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_take", 32'({out_valid, in_ready, busy}), 32'b010);
`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
        exp_total = (32'(exp_total) + 32'(eh) > 32'hFFFF) ? 16'hFFFF : exp_total + 16'(eh);
        check("hit_total", 32'(hit_total), 32'(exp_total));
`endif
    endtask

    // Accept a word and stop after the given number of shift edges (#1 past the last one).
    task automatic start_and_shift(input logic [7:0] d, input int edges);
        in_valid = 1'b1;
        in_data  = d;
        in_chain = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;

        vecs[0]  = '{8'h0B, 1'b0, 4'd1, 8'h01};
        vecs[1]  = '{8'hB6, 1'b0, 4'd2, 8'h12};
        vecs[2]  = '{8'h05, 1'b0, 4'd0, 8'h00};
        vecs[3]  = '{8'h80, 1'b1, 4'd1, 8'h80};
        vecs[4]  = '{8'h05, 1'b0, 4'd0, 8'h00};
        vecs[5]  = '{8'h80, 1'b0, 4'd0, 8'h00};
        vecs[6]  = '{8'h2D, 1'b0, 4'd1, 8'h04};
        vecs[7]  = '{8'hB6, 1'b1, 4'd3, 8'h92};
        vecs[8]  = '{8'hDB, 1'b0, 4'd2, 8'h09};
        vecs[9]  = '{8'hFF, 1'b0, 4'd0, 8'h00};
        vecs[10] = '{8'h00, 1'b0, 4'd0, 8'h00};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_chain = 1'b0;
        in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'({in_ready, busy, out_valid, out_hits, out_map}),
              32'({1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Vector 1 also exercises out_ready held high before the result appears.
        for (int i = 0; i < 11; i++)
            run_word(vecs[i].data, vecs[i].chain, vecs[i].hits, vecs[i].map, (i == 1), 0);

        run_word(8'h0B, 1'b0, 4'd1, 8'h01, 1'b0, 5);

        // Reset in the middle of SHIFT: immediate reset values, result never appears.
        start_and_shift(8'hB6, 3);
        reset = 1'b1;
        #1;
        check("reset_mid_shift", 32'({in_ready, busy, out_valid, out_hits, out_map}),
              32'({1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
        @(negedge clk);
        reset = 1'b0;
`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
        exp_total = '0;
        check("hit_total_reset", 32'(hit_total), 32'd0);
`endif
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_valid_after_reset", 32'(seen), 32'd0);
        run_word(8'h0B, 1'b0, 4'd1, 8'h01, 1'b0, 0);

        // Clear after bits 7..5 of 0xB6 (detector in S3), with a competing in_valid.
        start_and_shift(8'hB6, 3);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h0B;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_idle", 32'({in_ready, busy, out_valid, out_hits, out_map}),
              32'({1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
        exp_total = '0;
        check("hit_total_clear", 32'(hit_total), 32'd0);
`endif
        run_word(8'h80, 1'b1, 4'd0, 8'h00, 1'b0, 0);
        run_word(8'h0B, 1'b0, 4'd1, 8'h01, 1'b0, 0);

`ifdef SEQ_DETECT_CTRL_HIT_TOTAL_EN
        @(negedge clk);
        force dut.hit_total = 16'hFFFE;
        @(negedge clk);
        release dut.hit_total;
        exp_total = 16'hFFFE;
        #1;
        run_word(8'hB6, 1'b0, 4'd2, 8'h12, 1'b0, 0);
        check("hit_total_sat", 32'(hit_total), 32'hFFFF);
        run_word(8'h0B, 1'b0, 4'd1, 8'h01, 1'b0, 0);
        check("hit_total_stay", 32'(hit_total), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
